prio_arbiter_4: RTL and testbench
=================================

# prio_arbiter_4

- Sequential 4-requester arbiter that shares one resource, such as a downstream encoder/datapath port.
- Arbitration policy is selectable per decision:
  - fixed priority, LSB-first;
  - fixed priority, MSB-first;
  - round-robin.
- A grant is held until the owner drops its request; an optional hold limit preempts the owner when others are waiting.
- Sits between up to four request sources and the shared resource's select/enable inputs.

## Interface

Parameters:
- MAX_HOLD, default 16: maximum consecutive granted cycles while other requests are pending. Range 0..255; 0 disables preemption.

Ports:
- clk  input  1  rising-edge clock (the only clock).
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; req[i] is level-held by requester i for as long as it wants the resource.
- mode  input  2  policy select:
  - 00 = LSB-first fixed (req[0] highest);
  - 01 = MSB-first fixed (req[3] highest);
  - 10 = round-robin;
  - 11 = treated as 00.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- gnt_id  output  2  binary index of current owner, registered; holds last owner when idle.
- busy  output  1  high while any gnt bit is set, registered.

## Operation

- States:
  - IDLE: no owner.
  - OWNED: exactly one gnt bit set.
- Arbitration happens only:
  - in IDLE;
  - at release;
  - at preemption.
- mode is sampled only at arbitration; a mode change during OWNED has no effect until the next arbitration.
- Fixed modes: winner is the first set bit in priority order, as defined by mode.
- Round-robin:
  - Pointer rr_last (2 bits) holds the last winner.
  - Search order is rr_last+1, rr_last+2, … with wrap-around modulo 4.
  - rr_last updates on every grant, in every mode.
- Transitions:
  - IDLE, req==0: stay IDLE.
  - IDLE, req!=0: OWNED; gnt=winner, gnt_id=winner, hold counter=0.
  - OWNED, req[owner]==1, no preemption: stay; hold counter increments, saturating at 255.
  - OWNED, req[owner]==0, other req bits set: direct handoff to the new winner with no idle cycle; counter=0.
  - OWNED, req[owner]==0, req==0: IDLE; gnt=0, busy=0; gnt_id unchanged.
  - Preemption:
    - Condition: MAX_HOLD!=0, hold counter==MAX_HOLD-1, and (req & ~gnt)!=0.
    - Re-arbitrate with the owner masked out.
    - Winner takes the grant next edge; counter=0.
    - The preempted requester stays eligible in later arbitrations if its req stays high.
  - Preemption condition met but no other req pending: owner keeps the grant, counter saturates, and preemption fires as soon as another request appears.
- gnt is always one-hot or zero; never two bits set.
- Reset values:
  - gnt=0000, gnt_id=00, busy=0;
  - state IDLE, hold counter=0;
  - rr_last=11, so req[0] wins the first round-robin arbitration.

## Timing

- Grant latency: req sampled at edge n, gnt valid after edge n. That is one cycle from req assertion to gnt.
- Release latency: req[owner] low at edge n, gnt changes after edge n.
- Handoff: previous gnt bit clears and new gnt bit sets on the same edge.
- Preemption: owner holds gnt for exactly MAX_HOLD cycles when contended; the new owner's gnt appears on the following edge.
- All outputs come directly from flops; there is no combinational path from req or mode to outputs.
- Asynchronous reset:
  - rst_n low forces all outputs and state to reset values immediately, including mid-grant.
  - First arbitration occurs at the first clk edge after rst_n rises.
- A requester dropping req and re-raising it in the next cycle is a new request and competes normally.

## Test plan

- Reset and idle: assert rst_n=0 mid-grant → gnt=0000, busy=0, gnt_id=00 without waiting for clk. Release with req=0000 → outputs stay zero.
- Fixed priority:
  - mode=00, req=1010 → gnt=0010, gnt_id=01 one cycle later.
  - Repeat with mode=01 → gnt=1000, gnt_id=11.
  - Change mode while owned → grant unchanged.
- Round-robin: mode=10, req=1111 held; each owner drops req for one cycle after being granted → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles between handoffs.
- Preemption:
  - MAX_HOLD=4, mode=00, req=0001 held, then req[2] raised → gnt=0001 for 4 cycles total, then 0100.
  - After req[2] drops → gnt returns to 0001.
- Preemption disabled and uncontended:
  - MAX_HOLD=0 with req=0011 held 300 cycles → gnt=0001 throughout.
  - MAX_HOLD=4 with req=0001 only → grant held indefinitely.
- Release to idle: owner drops req with no others pending → gnt=0000, busy=0 next edge, gnt_id keeps the last owner. New req=0100 → gnt=0100 one cycle later.

Source files
------------

// File: rtl/prio_arbiter_4.sv
`default_nettype none
// ============================================================================
// prio_arbiter_4 : 4-requester arbiter (LSB/MSB fixed or round-robin) with
//                  grant hold and optional hold-limit preemption.
// Revision 1.0
// ============================================================================
module prio_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  // Counter parks at the preemption threshold so a late contender still triggers it.
  localparam logic [7:0] HOLD_SAT   = PREEMPT_EN ? 8'(MAX_HOLD - 1) : 8'd255;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic [1:0] rr_last_q, rr_last_d;
  logic [7:0] hold_q, hold_d;

  logic [3:0] w_others;
  logic       w_own_req;
  logic       w_preempt;
  logic       w_do_arb;
  logic [3:0] w_arb_req;
  logic [1:0] w_win;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] m,
                                      input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] off;
    logic [7:0] dbl;
    logic [3:0] rot;
    idx = 2'd0;
    off = last + 2'd1;
    dbl = {r, r};
    rot = dbl[off +: 4];
    case (m)
      2'b01: begin
        for (int i = 0; i < 4; i++) if (r[i]) idx = 2'(i);
      end
      2'b10: begin
        for (int i = 3; i >= 0; i--) if (rot[i]) idx = off + 2'(i);
      end
      default: begin
        for (int i = 3; i >= 0; i--) if (r[i]) idx = 2'(i);
      end
    endcase
    return idx;
  endfunction

  always_comb begin
    w_others  = req & ~gnt_q;
    w_own_req = |(req & gnt_q);
    w_preempt = PREEMPT_EN && (hold_q == HOLD_SAT) && (|w_others);

    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    rr_last_d = rr_last_q;
    hold_d    = hold_q;
    w_do_arb  = 1'b0;
    w_arb_req = req;
    w_win     = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (|req) w_do_arb = 1'b1;
      end
      S_OWNED: begin
        if (!w_own_req) begin
          if (|req) begin
            w_do_arb = 1'b1;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else if (w_preempt) begin
          w_arb_req = w_others;
          w_do_arb  = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    if (w_do_arb) begin
      w_win     = pick(w_arb_req, mode, rr_last_q);
      state_d   = S_OWNED;
      gnt_d     = 4'(4'b0001 << w_win);
      gnt_id_d  = w_win;
      busy_d    = 1'b1;
      rr_last_d = w_win;
      hold_d    = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'b00;
      busy_q    <= 1'b0;
      rr_last_q <= 2'b11;
      hold_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter_4.sv
`default_nettype none
// ============================================================================
// tb_prio_arbiter_4 : directed + random bench, three MAX_HOLD variants (16/4/0)
// Revision 1.0
// ============================================================================
module tb_prio_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] mode;
  logic [3:0] gnt_w [3];
  logic [1:0] id_w  [3];
  logic       busy_w[3];

  int c_hold[3] = '{16, 4, 0};

  // Reference state per instance: owner, last gnt_id, rr pointer, cycles held
  bit m_busy[3];
  int m_own [3];
  int m_id  [3];
  int m_rr  [3];
  int m_held[3];

  int n_checks = 0;
  int n_errors = 0;

  prio_arbiter_4 #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_w[0]), .gnt_id(id_w[0]), .busy(busy_w[0]));
  prio_arbiter_4 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_w[1]), .gnt_id(id_w[1]), .busy(busy_w[1]));
  prio_arbiter_4 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_w[2]), .gnt_id(id_w[2]), .busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] r, input logic [1:0] m, input int last);
    int idx;
    for (int k = 0; k < 4; k++) begin
      if (m == 2'b01)      idx = 3 - k;
      else if (m == 2'b10) idx = (last + 1 + k) % 4;
      else                 idx = k;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_grant(input int d, input int w);
    m_busy[d] = 1'b1;
    m_own[d]  = w;
    m_id[d]   = w;
    m_rr[d]   = w;
    m_held[d] = 1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 1'b0; m_own[d] = 0; m_id[d] = 0; m_rr[d] = 3; m_held[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [3:0] others;
    if (!m_busy[d]) begin
      if (req != 4'b0) model_grant(d, ref_pick(req, mode, m_rr[d]));
    end else if (!req[m_own[d]]) begin
      if (req != 4'b0) model_grant(d, ref_pick(req, mode, m_rr[d]));
      else             m_busy[d] = 1'b0;
    end else begin
      others = req & ~(4'b0001 << m_own[d]);
      if (c_hold[d] != 0 && m_held[d] >= c_hold[d] && others != 4'b0)
        model_grant(d, ref_pick(others, mode, m_rr[d]));
      else
        m_held[d]++;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    for (int d = 0; d < 3; d++) begin
      eg = m_busy[d] ? 4'(4'b0001 << m_own[d]) : 4'b0000;
      chk($sformatf("gnt[%0d]", d),    32'(gnt_w[d]),  32'(eg));
      chk($sformatf("gnt_id[%0d]", d), 32'(id_w[d]),   32'(m_id[d]));
      chk($sformatf("busy[%0d]", d),   32'(busy_w[d]), 32'(m_busy[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_all();
  endtask

  // Assert reset away from any clock edge and confirm outputs clear immediately.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_gnt[%0d]", d),  32'(gnt_w[d]),  32'h0);
      chk($sformatf("rst_id[%0d]", d),   32'(id_w[d]),   32'h0);
      chk($sformatf("rst_busy[%0d]", d), 32'(busy_w[d]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 2'b00;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) tick();

    // Fixed LSB-first, then a mode change while owned
    req = 4'b1010; mode = 2'b00;
    tick();
    chk("lsb_gnt", 32'(gnt_w[0]), 32'h2);
    chk("lsb_id",  32'(id_w[0]),  32'h1);
    mode = 2'b01;
    repeat (2) tick();
    chk("mode_chg_hold", 32'(gnt_w[0]), 32'h2);
    req = 4'b0000;
    tick();

    // Fixed MSB-first
    req = 4'b1010; mode = 2'b01;
    tick();
    chk("msb_gnt", 32'(gnt_w[0]), 32'h8);
    chk("msb_id",  32'(id_w[0]),  32'h3);
    repeat (2) tick();

    // Mid-grant reset, then round-robin rotation from the reset pointer
    async_reset();
    mode = 2'b10; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_seq%0d", i), 32'(gnt_w[0]), 32'(rr_exp[i]));
      req = 4'b1111 & ~(4'b0001 << m_own[0]);
    end
    req = 4'b0000;
    repeat (2) tick();
    chk("idle_id_kept", 32'(id_w[0]), 32'h0);

    // Preemption with MAX_HOLD=4 (instance 1)
    mode = 2'b00; req = 4'b0001;
    tick();
    req = 4'b0101;
    repeat (3) tick();
    chk("pre_still0", 32'(gnt_w[1]), 32'h1);
    tick();
    chk("pre_to2", 32'(gnt_w[1]), 32'h4);
    chk("pre_no16", 32'(gnt_w[0]), 32'h1);
    tick();
    req = 4'b0001;
    tick();
    chk("pre_back0", 32'(gnt_w[1]), 32'h1);
    req = 4'b0000;
    tick();

    // MAX_HOLD=0 never preempts; uncontended owner is never preempted
    req = 4'b0011;
    repeat (300) tick();
    chk("nopre_0", 32'(gnt_w[2]), 32'h1);
    req = 4'b0001;
    repeat (40) tick();
    chk("uncont_4", 32'(gnt_w[1]), 32'h1);
    req = 4'b0000;
    tick();
    chk("rel_busy", 32'(busy_w[1]), 32'h0);
    req = 4'b0100;
    tick();
    chk("regrant", 32'(gnt_w[1]), 32'h4);
    chk("regrant_id", 32'(id_w[1]), 32'h2);

    // Random traffic with sticky requests and occasional mode changes/resets
    for (int n = 0; n < 3000; n++) begin
      req = req ^ 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) async_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
